// File: rtl/screen_draw_ctrl_pkg.sv
// Shared definitions for the raster sequencer: screen codes, frame geometry
// and the sequencer state encoding.
package screen_draw_ctrl_pkg;

  localparam int H_PIX   = 160;
  localparam int V_PIX   = 120;
  localparam int NUM_PIX = H_PIX * V_PIX;
  localparam int ADDR_W  = 15;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {
    SCR_TITLE = 2'b00,
    SCR_BG    = 2'b01,
    SCR_WIN   = 2'b10,
    SCR_LOSE  = 2'b11
  } screen_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_FIN
  } state_e;

endpackage

// File: rtl/screen_draw_ctrl_raster_counter.sv
// Pixel walker: produces x/y and the linear ROM address in lock-step,
// using an incrementing address rather than y*H_PIX+x.
module screen_draw_ctrl_raster_counter
  import screen_draw_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [X_W-1:0]    ax_o,
  output logic [Y_W-1:0]    ay_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [X_W-1:0]    ax_q;
  logic [Y_W-1:0]    ay_q;
  logic [ADDR_W-1:0] addr_q;

  // Clear wins over step so the walker is parked at pixel 0 between frames.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ax_q   <= '0;
      ay_q   <= '0;
      addr_q <= '0;
    end else if (clear_i) begin
      ax_q   <= '0;
      ay_q   <= '0;
      addr_q <= '0;
    end else if (step_i) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (ax_q == X_W'(H_PIX - 1)) begin
        ax_q <= '0;
        ay_q <= ay_q + Y_W'(1);
      end else begin
        ax_q <= ax_q + X_W'(1);
      end
    end
  end

  assign ax_o   = ax_q;
  assign ay_o   = ay_q;
  assign addr_o = addr_q;
  assign last_o = (addr_q == LAST_ADDR);

endmodule

// File: rtl/screen_draw_ctrl.sv
// Raster sequencer: walks every pixel once per frame, drives the shared ROM
// address and the ROM-latency-aligned VGA x/y/plot, freezing SCREEN_SEL per frame.
module screen_draw_ctrl
  import screen_draw_ctrl_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              RESETN,
  input  logic [1:0]        SCREEN,
  input  logic              START,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic [1:0]        SCREEN_SEL,
  output logic [X_W-1:0]    VGA_X,
  output logic [Y_W-1:0]    VGA_Y,
  output logic              PLOT,
  output logic              BUSY,
  output logic              DONE
);

  state_e             state_q;
  logic               pending_q;
  logic               pending_d;
  logic [1:0]         prevScreen_q;
  logic [1:0]         screenSel_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         flushCnt_q;

  logic [X_W-1:0]     xPipe_q [ROM_LAT];
  logic [Y_W-1:0]     yPipe_q [ROM_LAT];
  logic [ROM_LAT-1:0] validPipe_q;

  logic               scanning;
  logic               redrawReq;
  logic [X_W-1:0]     rasterX;
  logic [Y_W-1:0]     rasterY;
  logic               rasterLast;

  assign scanning  = (state_q == ST_SCAN);
  assign redrawReq = START | (SCREEN != prevScreen_q);
  assign pending_d = pending_q | redrawReq;

  screen_draw_ctrl_raster_counter u_raster_counter (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESETN),
    .clear_i (!scanning || rasterLast),
    .step_i  (scanning),
    .ax_o    (rasterX),
    .ay_o    (rasterY),
    .addr_o  (ROM_ADDR),
    .last_o  (rasterLast)
  );

  // Requests arriving while busy only accumulate in pending; the frame that
  // starts from IDLE latches SCREEN, which already serves any coincident request.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b1;
      prevScreen_q <= SCR_TITLE;
      screenSel_q  <= SCR_TITLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      flushCnt_q   <= '0;
    end else begin
      prevScreen_q <= SCREEN;
      done_q       <= 1'b0;
      pending_q    <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            state_q     <= ST_SCAN;
            pending_q   <= 1'b0;
            screenSel_q <= SCREEN;
            busy_q      <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (rasterLast) begin
            state_q    <= ST_FLUSH;
            flushCnt_q <= '0;
          end
        end
        ST_FLUSH: begin
          if (flushCnt_q == 2'(ROM_LAT - 1)) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            flushCnt_q <= flushCnt_q + 2'd1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Coordinates only advance with a valid pixel, so VGA_X/VGA_Y hold when idle.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      validPipe_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        xPipe_q[i] <= '0;
        yPipe_q[i] <= '0;
      end
    end else begin
      validPipe_q[0] <= scanning;
      if (scanning) begin
        xPipe_q[0] <= rasterX;
        yPipe_q[0] <= rasterY;
      end
      for (int i = 1; i < ROM_LAT; i++) begin
        validPipe_q[i] <= validPipe_q[i-1];
        if (validPipe_q[i-1]) begin
          xPipe_q[i] <= xPipe_q[i-1];
          yPipe_q[i] <= yPipe_q[i-1];
        end
      end
    end
  end

  assign SCREEN_SEL = screenSel_q;
  assign VGA_X      = xPipe_q[ROM_LAT-1];
  assign VGA_Y      = yPipe_q[ROM_LAT-1];
  assign PLOT       = validPipe_q[ROM_LAT-1];
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Scoreboard bench for screen_draw_ctrl: stimulus queues the expected screen
// of each frame, a negedge monitor checks every plotted pixel and frame end.
module tb_screen_draw_ctrl;

  parameter int ROM_LAT = 1;

  localparam int W = 160;
  localparam int H = 120;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        resetN;
  logic [1:0]  screen;
  logic        start;
  logic [14:0] romAddr;
  logic [1:0]  screenSel;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;
  logic        plot;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  logic [1:0]  expSel[$];
  logic [14:0] addrHist[4];
  logic [1:0]  curSel;
  bit          inFrame = 1'b0;
  bit          prevBusy = 1'b0;
  bit          prevDone = 1'b0;
  int          cyc = 0;
  int          busyLen = 0;
  int          plotCount = 0;
  int          startCycle = 0;
  int          firstPlotCycle = 0;
  int          lastPlotCycle = 0;
  int          expX = 0;
  int          expY = 0;
  int          doneCount = 0;

  screen_draw_ctrl #(.ROM_LAT(ROM_LAT)) dut (
    .CLOCK_50   (clock),
    .RESETN     (resetN),
    .SCREEN     (screen),
    .START      (start),
    .ROM_ADDR   (romAddr),
    .SCREEN_SEL (screenSel),
    .VGA_X      (vgaX),
    .VGA_Y      (vgaY),
    .PLOT       (plot),
    .BUSY       (busy),
    .DONE       (done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the expected screen at each frame start and checks every
  // plotted pixel against a walking x/y model plus the address issued earlier.
  always @(negedge clock) begin
    cyc++;
    for (int i = 3; i > 0; i--) addrHist[i] = addrHist[i-1];
    addrHist[0] = romAddr;
    if (!resetN) begin
      inFrame  = 1'b0;
      prevBusy = 1'b0;
      prevDone = 1'b0;
    end else begin
      if (busy && !prevBusy) begin
        if (expSel.size() == 0) begin
          checkOutput("frame_expected", 64'(expSel.size()), 64'd1);
        end else begin
          curSel     = expSel.pop_front();
          inFrame    = 1'b1;
          busyLen    = 0;
          plotCount  = 0;
          expX       = 0;
          expY       = 0;
          startCycle = cyc;
        end
      end
      if (busy) busyLen++;
      if (plot) begin
        if (!inFrame) begin
          checkOutput("stray_plot", 64'(plot), 64'd0);
        end else begin
          if (plotCount == 0) begin
            firstPlotCycle = cyc;
            checkOutput("plot_latency", 64'(cyc - startCycle), 64'(ROM_LAT));
          end
          checkOutput("pixel", {32'd0, vgaX, vgaY, screenSel, addrHist[ROM_LAT]},
                      {32'd0, 8'(expX), 7'(expY), curSel, 15'(expY * W + expX)});
          plotCount++;
          lastPlotCycle = cyc;
          if (expX == W - 1) begin
            expX = 0;
            expY++;
          end else begin
            expX++;
          end
        end
      end
      if (done) begin
        checkOutput("done_width", 64'(prevDone), 64'd0);
        doneCount++;
        if (inFrame) begin
          checkOutput("frame_count", {32'(plotCount), 32'(busyLen)}, {32'(NPIX), 32'(NPIX + ROM_LAT)});
          checkOutput("frame_timing", {16'(busy), 16'(lastPlotCycle - firstPlotCycle + 1), 32'(cyc - lastPlotCycle)},
                      {16'd0, 16'(NPIX), 32'd1});
          inFrame = 1'b0;
        end else begin
          checkOutput("done_outside_frame", 64'(inFrame), 64'd1);
        end
      end
      prevBusy = busy;
      prevDone = done;
    end
  end

  task automatic waitPixel(input int x, input int y, input int budget);
    int n = 0;
    bit found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clock);
      n++;
      if (plot && vgaX == 8'(x) && vgaY == 7'(y)) found = 1'b1;
    end
    if (!found) checkOutput($sformatf("wait_pixel_%0d_%0d", x, y), 64'(found), 64'd1);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    bit found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clock);
      n++;
      if (done) found = 1'b1;
    end
    if (!found) checkOutput("wait_done", 64'(found), 64'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic applyStimulus();
    resetN = 1'b0;
    screen = 2'b00;
    start  = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_state", {35'd0, romAddr, screenSel, vgaX, vgaY, plot, busy, done}, 64'd0);

    // Frame A: title screen, with a screen change and extra requests mid-frame.
    expSel.push_back(2'b00);
    resetN = 1'b1;
    @(negedge clock);
    checkOutput("busy_rise", {62'd0, busy, plot}, 64'd2);
    repeat (ROM_LAT) @(negedge clock);
    checkOutput("first_plot", {48'd0, plot, vgaX, vgaY}, {48'd0, 1'b1, 8'd0, 7'd0});

    waitPixel(40, 31, 25000);
    screen = 2'b10;
    expSel.push_back(2'b10);
    waitPixel(80, 37, 25000);
    pulseStart();
    waitPixel(120, 43, 25000);
    pulseStart();
    waitPixel(40, 56, 25000);
    pulseStart();
    waitPixel(80, 62, 25000);
    screen = 2'b11;
    @(negedge clock);
    screen = 2'b10;
    waitDone(25000);

    // Frame B: win screen, aborted by reset at pixel 8000.
    waitPixel(0, 50, 25000);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("reset_mid", {35'd0, romAddr, screenSel, vgaX, vgaY, plot, busy, done}, 64'd0);
    checkOutput("queue_before_reset", 64'(expSel.size()), 64'd0);
    screen = 2'b00;
    repeat (3) @(negedge clock);

    // Frame C: fresh full frame after release.
    expSel.push_back(2'b00);
    resetN = 1'b1;
    waitDone(25000);
    repeat (20) @(negedge clock);
    checkOutput("idle_outputs", {30'd0, romAddr, plot, busy, done, vgaX, vgaY, screenSel},
                {30'd0, 15'd0, 1'b0, 1'b0, 1'b0, 8'd159, 7'd119, 2'b00});
    checkOutput("done_count", 64'(doneCount), 64'd2);
    checkOutput("queue_empty", 64'(expSel.size()), 64'd0);
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
